// File: rtl/updown_counter_nbit.sv
// Parametrised registered up/down counter with load, enable, programmable step,
// per-cycle wrap/saturate choice, overflow/underflow pulses and terminal-count flags.
module updown_counter_nbit #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             r_at_max;
    logic             r_at_min;

    // The extra top bit of each result is the carry (add) or borrow (subtract).
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_ovf;
    logic             w_next_unf;

    assign w_sum  = {1'b0, r_count} + {1'b0, step};
    assign w_diff = {1'b0, r_count} - {1'b0, step};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a signal unassigned and no latch is inferred.
        w_next_count = r_count;
        w_next_ovf   = 1'b0;
        w_next_unf   = 1'b0;
        if (load) begin
            w_next_count = load_val;
        end else if (en) begin
            if (up) begin
                if (w_sum[WIDTH]) begin
                    w_next_ovf   = 1'b1;
                    w_next_count = sat ? MAX_VAL : w_sum[WIDTH-1:0];
                end else begin
                    w_next_count = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_diff[WIDTH]) begin
                    w_next_unf   = 1'b1;
                    w_next_count = sat ? MIN_VAL : w_diff[WIDTH-1:0];
                end else begin
                    w_next_count = w_diff[WIDTH-1:0];
                end
            end
        end
    end

    // Flags are computed from the next-state value so they move on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_count  <= RST_VAL;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_at_max <= (RST_VAL == MAX_VAL);
            r_at_min <= (RST_VAL == MIN_VAL);
        end else begin
            r_count  <= w_next_count;
            r_ovf    <= w_next_ovf;
            r_unf    <= w_next_unf;
            r_at_max <= (w_next_count == MAX_VAL);
            r_at_min <= (w_next_count == MIN_VAL);
        end
    end

    assign count  = r_count;
    assign ovf    = r_ovf;
    assign unf    = r_unf;
    assign at_max = r_at_max;
    assign at_min = r_at_min;

endmodule

// File: tb/tb_updown_counter_nbit.sv
// Self-checking bench for updown_counter_nbit (WIDTH=6, RST_VAL=0): a directed
// vector table plus hand-written sequences for wrap-up, reset and async reset.
module tb_updown_counter_nbit;

    localparam int W = 6;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic         up;
    logic         sat;
    logic [W-1:0] step;
    logic [W-1:0] count;
    logic         ovf;
    logic         unf;
    logic         at_max;
    logic         at_min;

    typedef struct {
        string        name;
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic         up;
        logic         sat;
        logic [W-1:0] st;
        logic [W-1:0] e_cnt;
        logic         e_ovf;
        logic         e_unf;
        logic         e_max;
        logic         e_min;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    updown_counter_nbit #(.WIDTH(W), .RST_VAL(6'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .up       (up),
        .sat      (sat),
        .step     (step),
        .count    (count),
        .ovf      (ovf),
        .unf      (unf),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] e_cnt, input logic e_ovf,
                         input logic e_unf, input logic e_max, input logic e_min);
        n_vec++;
        if (count !== e_cnt || ovf !== e_ovf || unf !== e_unf || at_max !== e_max || at_min !== e_min) begin
            n_err++;
            $display("FAIL %s: got count=%0d ovf=%b unf=%b at_max=%b at_min=%b, want count=%0d ovf=%b unf=%b at_max=%b at_min=%b",
                     name, count, ovf, unf, at_max, at_min, e_cnt, e_ovf, e_unf, e_max, e_min);
        end
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e,
                         input logic u, input logic s, input logic [W-1:0] st);
        load     = ld;
        load_val = lv;
        en       = e;
        up       = u;
        sat      = s;
        step     = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string nm, input logic ld, input logic [W-1:0] lv,
                                input logic e, input logic u, input logic s, input logic [W-1:0] st,
                                input logic [W-1:0] ec, input logic eo, input logic eu,
                                input logic emax, input logic emin);
        vec_t v;
        v.name = nm; v.ld = ld; v.lv = lv; v.en = e; v.up = u; v.sat = s; v.st = st;
        v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu; v.e_max = emax; v.e_min = emin;
        vecs.push_back(v);
    endfunction

    initial begin
        //   name            ld lv    en up sat step   cnt   ovf unf max min
        add("load62",        1, 6'd62, 0, 0, 0, 6'd0,  6'd62, 0, 0, 0, 0);
        add("sat_up",        0, 6'd0,  1, 1, 1, 6'd3,  6'd63, 1, 0, 1, 0);
        add("sat_up_hold",   0, 6'd0,  1, 1, 1, 6'd3,  6'd63, 1, 0, 1, 0);
        add("en_off",        0, 6'd0,  0, 1, 1, 6'd3,  6'd63, 0, 0, 1, 0);
        add("load2",         1, 6'd2,  0, 0, 0, 6'd0,  6'd2,  0, 0, 0, 0);
        add("wrap_dn",       0, 6'd0,  1, 0, 0, 6'd5,  6'd61, 0, 1, 0, 0);
        add("wrap_dn_next",  0, 6'd0,  1, 0, 0, 6'd5,  6'd56, 0, 0, 0, 0);
        add("load4",         1, 6'd4,  0, 0, 0, 6'd0,  6'd4,  0, 0, 0, 0);
        add("sat_dn",        0, 6'd0,  1, 0, 1, 6'd10, 6'd0,  0, 1, 0, 1);
        add("sat_dn_hold",   0, 6'd0,  1, 0, 1, 6'd10, 6'd0,  0, 1, 0, 1);
        add("load_over_en",  1, 6'd40, 1, 1, 0, 6'd7,  6'd40, 0, 0, 0, 0);
        add("step0_up",      0, 6'd0,  1, 1, 0, 6'd0,  6'd40, 0, 0, 0, 0);
        add("step0_dn",      0, 6'd0,  1, 0, 1, 6'd0,  6'd40, 0, 0, 0, 0);
        add("wrap_to_0",     0, 6'd0,  1, 1, 0, 6'd24, 6'd0,  1, 0, 0, 1);
        add("up63_nocarry",  0, 6'd0,  1, 1, 0, 6'd63, 6'd63, 0, 0, 1, 0);
        add("up63_wrap",     0, 6'd0,  1, 1, 0, 6'd63, 6'd62, 1, 0, 0, 0);
        add("load63",        1, 6'd63, 0, 1, 1, 6'd5,  6'd63, 0, 0, 1, 0);
        add("max_step0_sat", 0, 6'd0,  1, 1, 1, 6'd0,  6'd63, 0, 0, 1, 0);
        add("dn63_exact",    0, 6'd0,  1, 0, 0, 6'd63, 6'd0,  0, 0, 0, 1);
        add("dn1_wrap",      0, 6'd0,  1, 0, 0, 6'd1,  6'd63, 0, 1, 1, 0);

        // Reset state, checked while rst is still high.
        rst = 1'b1;
        drive(0, 6'd0, 0, 0, 0, 6'd0);
        #12;
        check("reset_state", 6'd0, 0, 0, 0, 1);

        // Wrap-up: 64 unit steps from 0 come back to 0 with a single ovf pulse.
        @(negedge clk);
        rst = 1'b0;
        drive(0, 6'd0, 1, 1, 0, 6'd1);
        for (int i = 1; i <= 64; i++) begin
            logic [W-1:0] e;
            e = W'(i % 64);
            tick();
            check($sformatf("wrap_up_%0d", i), e, (i == 64), 1'b0, (i == 63), (i == 64));
        end

        // Directed table.
        foreach (vecs[k]) begin
            drive(vecs[k].ld, vecs[k].lv, vecs[k].en, vecs[k].up, vecs[k].sat, vecs[k].st);
            tick();
            check(vecs[k].name, vecs[k].e_cnt, vecs[k].e_ovf, vecs[k].e_unf, vecs[k].e_max, vecs[k].e_min);
        end

        // Async reset mid-count.
        drive(1, 6'd20, 0, 0, 0, 6'd0);
        tick();
        drive(0, 6'd0, 1, 1, 0, 6'd5);
        tick();
        check("pre_rst_25", 6'd25, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_now", 6'd0, 0, 0, 0, 1);
        repeat (2) tick();
        check("rst_held_2edges", 6'd0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("first_edge_after_rst", 6'd5, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/updown_counter_nbit.md
Name: updown_counter_nbit

Overview:
- Parametrised synchronous up/down counter; the registered successor to the 6-bit combinational incrementer.
- Adds load, enable, a programmable step, direction control, and a per-cycle choice of wrap or saturate.
- Drives registered overflow/underflow pulses and terminal-count flags.
- Sits in the ALU datapath as program/loop counter and general sequencing counter.

Parameters:
WIDTH, 6, bit width of count, load_val and step (legal range 2..32)
RST_VAL, 0, value loaded into count on reset (must fit in WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  count enable; when high, one step is applied per cycle
load  input  1  synchronous load of load_val; overrides en
load_val  input  WIDTH  value taken by count on load
up  input  1  1 = count up by step, 0 = count down by step
sat  input  1  1 = saturate at boundaries, 0 = wrap modulo 2^WIDTH
step  input  WIDTH  unsigned increment magnitude
count  output  WIDTH  current counter value (registered)
ovf  output  1  one-cycle pulse; last up-step exceeded 2^WIDTH-1
unf  output  1  one-cycle pulse; last down-step went below 0
at_max  output  1  count == 2^WIDTH-1 (registered, coherent with count)
at_min  output  1  count == 0 (registered, coherent with count)

Behaviour:
- Reset is asynchronous and active-high, on port rst. Clock is clk; there is a single clock domain.
- Reset values while rst is high and after release: count=RST_VAL, ovf=0, unf=0, at_max=(RST_VAL==2^WIDTH-1), at_min=(RST_VAL==0).
- Priority per rising edge: rst > load > en > hold.
- load=1: count<=load_val; ovf<=0; unf<=0; flags recomputed from load_val. up, sat, step and en are ignored.
- en=1, load=0, up=1: form sum = {1'b0,count} + {1'b0,step} in WIDTH+1 bits. Carry = sum[WIDTH].
  - No carry: count<=sum[WIDTH-1:0].
  - Carry and sat=0: count<=sum[WIDTH-1:0] (wrap); ovf<=1.
  - Carry and sat=1: count<=2^WIDTH-1; ovf<=1.
- en=1, load=0, up=0: form diff = {1'b0,count} - {1'b0,step} in WIDTH+1 bits. Borrow = diff[WIDTH].
  - No borrow: count<=diff[WIDTH-1:0].
  - Borrow and sat=0: count<=diff[WIDTH-1:0] (wrap); unf<=1.
  - Borrow and sat=1: count<=0; unf<=1.
- Saturated hold still flags: count at max with up=1, sat=1, step>0 leaves count unchanged and ovf<=1. The symmetric case at min with up=0 gives unf<=1.
- step=0 with en=1: count unchanged; ovf=unf=0.
- en=0, load=0: count holds; ovf<=0; unf<=0. Pulses never last more than one cycle unless re-triggered on the next edge.
- at_max/at_min are registered from the next-state value, so they change on the same edge as count. There is no combinational path from inputs to any output.
- Latency: 1 cycle from a sampled en/load to the updated count and flags.
- rst asserted mid-operation: all outputs take reset values immediately, without waiting for a clock edge. The first edge after deassertion applies normal priority.
- All arithmetic is unsigned; count never holds a value outside 0..2^WIDTH-1.

Test Plan (WIDTH=6, RST_VAL=0):
- Reset and wrap up: rst pulse, then en=1, up=1, sat=0, step=1 for 64 cycles -> count 0,1,…,63,0. ovf=1 exactly in the cycle count shows 0. at_max=1 when count=63.
- Saturate up: load 62, then en=1, up=1, sat=1, step=3 -> count=63, ovf=1. Next cycle, same inputs -> count=63, ovf=1. Then en=0 -> ovf=0.
- Wrap down: load 2, then en=1, up=0, sat=0, step=5 -> count=61, unf=1. Next step -> 56, unf=0.
- Saturate down: load 4, then up=0, sat=1, step=10 -> count=0, unf=1, at_min=1.
- Priority: load=1, en=1, load_val=40, step=7 -> count=40, ovf=unf=0. With step=0 and en=1 -> count stays 40.
- Async reset mid-count: count=25 while counting; assert rst between edges -> count=0, at_min=1 before the next clk edge. Hold rst across two edges -> count stays 0.
